posit_encode_product_es3: RTL and testbench

- Converts the raw serialized product of the es3 multiplier pipeline into a standard 32-bit posit (NBITS=32, ES=3).
- The raw product fields are sign, unbounded scale, unnormalized fraction, inf and zero. Conversion covers regime/exponent/fraction packing, round-to-nearest-even, saturation and sign handling.
- Sits directly downstream of the raw-product multiplier and is the encode end of the raw-product interface.
- Fully pipelined: 3 register stages, one result per cycle, no backpressure.

---
 rtl/posit_defines_es3.sv | 62 ++++++
 rtl/posit_encode_product_es3_if.sv | 15 +
 rtl/posit_round_pack_es3.sv | 54 +++++
 rtl/posit_encode_product_es3.sv | 127 ++++++++++++
 tb/tb_posit_encode_product_es3.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/posit_defines_es3.sv
// Shared constants, raw-product record and helpers for the es3 posit datapath.
package posit_defines_es3;

    localparam int NBITS     = 32;
    localparam int ES        = 3;
    localparam int FBITS     = 26;
    localparam int MBITS     = 54;
    localparam int MAX_SCALE = 240;
    localparam int POSIT_SERIALIZED_WIDTH_PRODUCT_ES3 = 67;

    typedef struct packed {
        logic              sgn;
        logic signed [9:0] scale;
        logic [MBITS-1:0]  fraction;
        logic              inf;
        logic              zero;
    } value_product;

    // Stage 0 holds the decoded regime geometry alongside the raw fraction.
    typedef struct packed {
        logic             sgn;
        logic             inf;
        logic             zero;
        logic             sat_hi;
        logic             sat_lo;
        logic             regime_pos;
        logic [6:0]       rlen;
        logic [2:0]       e;
        logic [MBITS-1:0] fraction;
    } stage0_t;

    // Stage 1 keeps magnitude plus guard in one word, with the sticky OR beside it.
    typedef struct packed {
        logic             sgn;
        logic             inf;
        logic             zero;
        logic             sat_hi;
        logic             sat_lo;
        logic [NBITS-1:0] top;
        logic             sticky;
    } stage1_t;

    function automatic value_product deserialize_prod(
        input logic [POSIT_SERIALIZED_WIDTH_PRODUCT_ES3-1:0] bits
    );
        value_product v;
        v.sgn      = bits[66];
        v.scale    = bits[65:56];
        v.fraction = bits[55:2];
        v.inf      = bits[1];
        v.zero     = bits[0];
        return v;
    endfunction

    function automatic logic [2*NBITS-1:0] shift_right(
        input logic [2*NBITS-1:0] value,
        input logic [6:0]         amount
    );
        return value >> amount;
    endfunction

endpackage

// File: rtl/posit_encode_product_es3_if.sv
// Raw-product in / encoded-posit out bundle between the multiplier and the encoder.
interface posit_encode_product_es3_if;
    import posit_defines_es3::*;

    logic [POSIT_SERIALIZED_WIDTH_PRODUCT_ES3-1:0] in;
    logic                                          start;
    logic [NBITS-1:0]                              result;
    logic                                          inf;
    logic                                          zero;
    logic                                          done;

    modport master (output in, output start, input result, input inf, input zero, input done);
    modport slave  (input in, input start, output result, output inf, output zero, output done);

endinterface

// File: rtl/posit_round_pack_es3.sv
// Round-to-nearest-even, saturation, sign and special-value packing of a posit magnitude.
module posit_round_pack_es3
    import posit_defines_es3::*;
(
    input  logic             sgn,
    input  logic [NBITS-2:0] mag_in,
    input  logic             guard,
    input  logic             sticky,
    input  logic             sat_hi,
    input  logic             sat_lo,
    input  logic             is_inf,
    input  logic             is_zero,
    output logic [NBITS-1:0] result,
    output logic             inf,
    output logic             zero
);

    localparam logic [NBITS-2:0] MAXPOS = {(NBITS-1){1'b1}};
    localparam logic [NBITS-2:0] MINPOS = {{(NBITS-2){1'b0}}, 1'b1};

    logic             round_up;
    logic [NBITS-1:0] rounded;
    logic [NBITS-2:0] mag;

    // Posits never round to zero or NaR, so both ends of the range clamp.
    always_comb begin
        round_up = guard & (sticky | mag_in[0]);
        rounded  = {1'b0, mag_in} + {{(NBITS-1){1'b0}}, round_up};
        mag      = rounded[NBITS-2:0];
        if (rounded[NBITS-1]) begin
            mag = MAXPOS;
        end
        if (mag == '0) begin
            mag = MINPOS;
        end
        if (sat_hi) begin
            mag = MAXPOS;
        end else if (sat_lo) begin
            mag = MINPOS;
        end

        result = sgn ? {1'b1, ~mag + 1'b1} : {1'b0, mag};
        inf    = 1'b0;
        zero   = 1'b0;
        if (is_inf) begin
            result = {1'b1, {(NBITS-1){1'b0}}};
            inf    = 1'b1;
        end else if (is_zero) begin
            result = '0;
            zero   = 1'b1;
        end
    end

endmodule

// File: rtl/posit_encode_product_es3.sv
// Three-stage encoder from the serialized raw multiplier product to a 32-bit es3 posit.
module posit_encode_product_es3
    import posit_defines_es3::*;
(
    input  logic                       clk,
    input  logic                       rst,
    posit_encode_product_es3_if.slave  bus
);

    localparam logic signed [10:0] SAT_LIMIT  = 11'(MAX_SCALE);
    localparam logic [6:0]         SHIFT_CLIP = 7'(NBITS);

    value_product        in_val;
    logic signed [10:0]  scale_ext;
    logic signed [10:0]  k;
    logic [10:0]         run_len;

    stage0_t s0_d, s0_q;
    logic    s0_valid_d, s0_valid_q;
    stage1_t s1_d, s1_q;
    logic    s1_valid_d, s1_valid_q;

    logic [2*NBITS-1:0] packed_word;
    logic [2*NBITS-1:0] fill_mask;
    logic [2*NBITS-1:0] shifted;

    logic [NBITS-1:0] pack_result;
    logic             pack_inf;
    logic             pack_zero;
    logic [NBITS-1:0] result_d, result_q;
    logic             inf_d, inf_q;
    logic             zero_d, zero_q;
    logic             done_d, done_q;

    // Regime run is k+1 ones for k>=0, -k zeros otherwise.
    always_comb begin
        in_val     = deserialize_prod(bus.in);
        scale_ext  = {in_val.scale[9], in_val.scale};
        k          = scale_ext >>> ES;
        run_len    = k[10] ? -k : k + 11'sd1;
        s0_valid_d = 1'b0;
        s0_d       = s0_q;
        if (bus.start) begin
            s0_valid_d      = 1'b1;
            s0_d.sgn        = in_val.sgn;
            s0_d.inf        = in_val.inf;
            s0_d.zero       = in_val.zero;
            s0_d.sat_hi     = scale_ext > SAT_LIMIT;
            s0_d.sat_lo     = scale_ext < -SAT_LIMIT;
            s0_d.regime_pos = ~k[10];
            s0_d.rlen       = (run_len > 11'(NBITS)) ? SHIFT_CLIP : run_len[6:0];
            s0_d.e          = in_val.scale[2:0];
            s0_d.fraction   = in_val.fraction;
        end
    end

    // Terminator leads the word; the shift opens room for the regime, which the mask fills for k>=0.
    always_comb begin
        packed_word = {~s0_q.regime_pos, s0_q.e,
                       s0_q.fraction[MBITS-1:MBITS-FBITS-2], {NBITS{1'b0}}};
        fill_mask   = s0_q.regime_pos ? ~shift_right({(2*NBITS){1'b1}}, s0_q.rlen) : '0;
        shifted     = shift_right(packed_word, s0_q.rlen) | fill_mask;

        s1_valid_d  = s0_valid_q;
        s1_d.sgn    = s0_q.sgn;
        s1_d.inf    = s0_q.inf;
        s1_d.zero   = s0_q.zero;
        s1_d.sat_hi = s0_q.sat_hi;
        s1_d.sat_lo = s0_q.sat_lo;
        s1_d.top    = shifted[2*NBITS-1:NBITS];
        s1_d.sticky = (|shifted[NBITS-1:0]) | (|s0_q.fraction[MBITS-FBITS-3:0]);
    end

    posit_round_pack_es3 u_round_pack (
        .sgn     (s1_q.sgn),
        .mag_in  (s1_q.top[NBITS-1:1]),
        .guard   (s1_q.top[0]),
        .sticky  (s1_q.sticky),
        .sat_hi  (s1_q.sat_hi),
        .sat_lo  (s1_q.sat_lo),
        .is_inf  (s1_q.inf),
        .is_zero (s1_q.zero),
        .result  (pack_result),
        .inf     (pack_inf),
        .zero    (pack_zero)
    );

    always_comb begin
        result_d = result_q;
        inf_d    = inf_q;
        zero_d   = zero_q;
        done_d   = s1_valid_q;
        if (s1_valid_q) begin
            result_d = pack_result;
            inf_d    = pack_inf;
            zero_d   = pack_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q       <= '0;
            s0_valid_q <= 1'b0;
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            result_q   <= '0;
            inf_q      <= 1'b0;
            zero_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            s0_q       <= s0_d;
            s0_valid_q <= s0_valid_d;
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
            result_q   <= result_d;
            inf_q      <= inf_d;
            zero_q     <= zero_d;
            done_q     <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.inf    = inf_q;
    assign bus.zero   = zero_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_posit_encode_product_es3.sv
// Directed bench for the es3 product encoder, scored against a bit-string posit model.
module tb_posit_encode_product_es3;
    import posit_defines_es3::*;

    logic clk = 1'b0;
    logic rst;

    posit_encode_product_es3_if bus();

    posit_encode_product_es3 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] res;
        logic        inf;
        logic        zero;
        bit          has_lit;
        logic [31:0] lit;
    } entry_t;

    entry_t      sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          armed    = 1'b0;
    bit          drv_has_lit = 1'b0;
    logic [31:0] drv_lit  = '0;
    logic [31:0] held_res = '0;
    logic        held_inf = 1'b0;
    logic        held_zero = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Posit built as an explicit bit string: regime, terminator, exponent, fraction.
    function automatic void model(input logic sgn, input int scale, input logic [53:0] frac,
                                  input logic inf_in, input logic zero_in,
                                  output logic [31:0] res, output logic inf_o, output logic zero_o);
        bit     bits[$];
        longint mag;
        int     k;
        int     e;
        bit     guard;
        bit     sticky;
        inf_o  = 1'b0;
        zero_o = 1'b0;
        if (inf_in) begin
            res   = 32'h8000_0000;
            inf_o = 1'b1;
            return;
        end
        if (zero_in) begin
            res    = 32'h0;
            zero_o = 1'b1;
            return;
        end
        if (scale > 240) begin
            mag = 64'h7FFF_FFFF;
        end else if (scale < -240) begin
            mag = 1;
        end else begin
            k = (scale >= 0) ? scale / 8 : -((-scale + 7) / 8);
            e = scale - 8 * k;
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) bits.push_back(1'b1);
                bits.push_back(1'b0);
            end else begin
                for (int i = 0; i < -k; i++) bits.push_back(1'b0);
                bits.push_back(1'b1);
            end
            for (int i = 2; i >= 0; i--) bits.push_back(e[i]);
            for (int i = 53; i >= 0; i--) bits.push_back(frac[i]);
            mag = 0;
            for (int i = 0; i < 31; i++) mag = mag * 2 + longint'(bits[i]);
            guard  = bits[31];
            sticky = 1'b0;
            for (int i = 32; i < bits.size(); i++) sticky = sticky | bits[i];
            if (guard && (sticky || mag[0])) mag++;
            if (mag > 64'h7FFF_FFFF) mag = 64'h7FFF_FFFF;
            if (mag == 0) mag = 1;
        end
        res = sgn ? {1'b1, 31'(64'h8000_0000 - mag)} : 32'(mag);
    endfunction

    // Single compare process: done must appear exactly 3 cycles after each start, outputs hold otherwise.
    always @(negedge clk) begin
        value_product v;
        entry_t       ent;
        bit           exp_done;
        if (armed) begin
            exp_done = (sb.size() > 0) && (sb[0].cyc + 3 == cyc);
            check_output("done", {31'b0, bus.done}, {31'b0, exp_done});
            if (exp_done) begin
                ent = sb.pop_front();
                check_output("result", bus.result, ent.res);
                check_output("inf", {31'b0, bus.inf}, {31'b0, ent.inf});
                check_output("zero", {31'b0, bus.zero}, {31'b0, ent.zero});
                if (ent.has_lit) check_output("literal", bus.result, ent.lit);
                held_res  = ent.res;
                held_inf  = ent.inf;
                held_zero = ent.zero;
            end else begin
                check_output("hold_result", bus.result, held_res);
                check_output("hold_inf", {31'b0, bus.inf}, {31'b0, held_inf});
                check_output("hold_zero", {31'b0, bus.zero}, {31'b0, held_zero});
            end
        end
        if (rst) begin
            sb.delete();
            held_res  = '0;
            held_inf  = 1'b0;
            held_zero = 1'b0;
            armed     = 1'b1;
        end else if (bus.start === 1'b1) begin
            v           = deserialize_prod(bus.in);
            ent.cyc     = cyc;
            ent.has_lit = drv_has_lit;
            ent.lit     = drv_lit;
            model(v.sgn, int'(v.scale), v.fraction, v.inf, v.zero, ent.res, ent.inf, ent.zero);
            sb.push_back(ent);
        end
    end

    task automatic apply_stimulus(input logic sgn, input int scale, input logic [53:0] frac,
                                  input logic inf_in, input logic zero_in,
                                  input bit has_lit, input logic [31:0] lit);
        logic [31:0] m_res;
        logic        m_inf;
        logic        m_zero;
        if (has_lit) begin
            model(sgn, scale, frac, inf_in, zero_in, m_res, m_inf, m_zero);
            check_output("model_pin", m_res, lit);
        end
        @(posedge clk);
        #1;
        bus.in      = {sgn, 10'(scale), frac, inf_in, zero_in};
        bus.start   = 1'b1;
        drv_has_lit = has_lit;
        drv_lit     = lit;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
    endtask

    int          stream_scale [8] = '{-20, -7, 3, 15, 47, 100, 200, 235};
    logic [53:0] stream_frac  [8] = '{54'h15555555555555, 54'h0, 54'h3FFFFFFFFFFFFF, 54'h00000018000000,
                                      54'h2AAAAAAAAAAAAA, 54'h12345678ABCDEF, 54'h3F00000000001, 54'h20000000000001};

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.in    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        apply_stimulus(0, 0, 54'h0, 0, 0, 1, 32'h4000_0000);
        idle(4);
        apply_stimulus(0, 1, 54'h0, 0, 0, 1, 32'h4400_0000);
        apply_stimulus(0, 0, 54'h20000000000000, 0, 0, 1, 32'h4200_0000);
        apply_stimulus(1, 0, 54'h0, 0, 0, 1, 32'hC000_0000);
        apply_stimulus(0, 0, 54'h8000000, 0, 0, 1, 32'h4000_0000);
        apply_stimulus(0, 0, 54'h18000000, 0, 0, 1, 32'h4000_0002);
        apply_stimulus(0, 0, 54'h8000001, 0, 0, 1, 32'h4000_0001);
        idle(2);
        apply_stimulus(0, 300, 54'h0, 0, 0, 1, 32'h7FFF_FFFF);
        apply_stimulus(0, -300, 54'h0, 0, 0, 1, 32'h0000_0001);
        apply_stimulus(1, -300, 54'h0, 0, 0, 1, 32'hFFFF_FFFF);
        apply_stimulus(0, 240, 54'h0, 0, 0, 1, 32'h7FFF_FFFF);
        apply_stimulus(1, 123, 54'h15555555555555, 1, 0, 1, 32'h8000_0000);
        apply_stimulus(0, 5, 54'h3, 0, 1, 1, 32'h0000_0000);
        apply_stimulus(1, -9, 54'h1, 1, 1, 1, 32'h8000_0000);
        idle(5);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(i[0], stream_scale[i], stream_frac[i], 0, 0, 0, 32'h0);
        end
        idle(3);
        apply_stimulus(1, -123, 54'h2F0F0F0F0F0F0F, 0, 0, 0, 32'h0);
        idle(5);

        apply_stimulus(0, 17, 54'h0, 0, 0, 0, 32'h0);
        apply_stimulus(1, 33, 54'h0, 0, 0, 0, 32'h0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);
        apply_stimulus(0, 1, 54'h0, 0, 0, 1, 32'h4400_0000);
        idle(6);

        check_output("drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
